record_store_arbiter: RTL and testbench
=======================================

# record_store_arbiter

Owns the play-record ring buffer and shares it between one writer (the result page appending a finished play) and two readers (reader 0: score-history page; reader 1: best-score lookup). It arbitrates one access per `prog_clk` cycle and maps logical record IDs (0 = newest) to physical slots. It returns tagged read data one cycle after grant. Optionally, it can wipe the store.

## Interface
- `DEPTH`, default 16: number of record slots; power of two, 2..128.
- `prog_clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `wr_req`  in  1: append request; hold with `wr_rec` stable until `wr_ack`.
- `wr_rec`  in  PlayRecord: record to append.
- `wr_ack`  out  1: combinational; the write commits at the closing edge of this cycle.
- `rd_req`  in  2: per-reader read request; hold with `rd_id` stable until the matching `rd_gnt` bit.
- `rd_id`  in  2×8: per-reader logical ID (byte).
- `rd_gnt`  out  2: combinational one-hot grant, at most one bit set.
- `rd_valid`  out  2: registered; pulses one cycle after grant, for the granted reader.
- `rd_hit`  out  1: registered; ID was < count at grant time.
- `rd_data`  out  PlayRecord: registered; shared bus, qualified by `rd_valid`.
- `count`  out  8: number of stored records, saturating at DEPTH.
- `busy`  out  1: clear in progress (`RECORD_CLEAR_EN` only; otherwise tied 0).
- `clr_req`  in  1: start wipe (present only with `RECORD_CLEAR_EN`).

## Operation
- FSM states: SERVE, plus CLEAR when the macro is defined.
- Priority in SERVE: `clr_req` > `wr_req` > readers.
- Readers are round-robin.
  - The `rr` bit names the favoured reader.
  - After granting reader k, `rr` := 1−k.
  - `rr` is unchanged when no reader is granted.
- A write grant commits `mem[wr_ptr]` <= `wr_rec`.
  - `wr_ptr` := (`wr_ptr`+1) mod DEPTH.
  - `count` := min(`count`+1, DEPTH).
  - When full, the write overwrites the oldest record.
- Read grant, physical slot = (`wr_ptr` − 1 − `rd_id`) mod DEPTH, using `wr_ptr` at the grant cycle.
  - Hit (`rd_id` < `count`): `rd_data` = slot contents, `rd_hit` = 1.
  - Miss: `rd_data` = all zeros, `rd_hit` = 0; `rd_valid` still pulses.
- Write wins a same-cycle collision with a read.
  - The read is granted in a later cycle.
  - The read then sees shifted IDs: ID 0 is the new record. This is intended.
- A requester that keeps its request asserted past its grant is treated as a new request.
- CLEAR (entered on `clr_req` in SERVE):
  - On entry: `count` := 0, `wr_ptr` := 0.
  - The FSM then zeroes slots 0..DEPTH−1, one per cycle.
  - `busy` = 1 and all grants/acks are 0 throughout.
  - Returns to SERVE after slot DEPTH−1 is written.
  - `clr_req` while in CLEAR is ignored.

## Timing
- Reset values: state SERVE, `wr_ptr` 0, `count` 0, `rr` 0 (reader 0 favoured), `rd_valid` 0, `rd_hit` 0, `rd_data` 0, `busy` 0. Memory contents are not reset; `count` masks them.
- `wr_ack`/`rd_gnt` are combinational: asserted in the same cycle as the qualifying request.
- Write latency: data is visible to a read granted in the next cycle.
- Read latency: `rd_valid`/`rd_data`/`rd_hit` are valid exactly 1 cycle after `rd_gnt`.
- Throughput: one access per cycle.
- `rst` during CLEAR aborts the wipe. The block is in SERVE with `count` 0 on the next cycle; un-wiped slots keep stale data that is never exposed.
- `rst` takes priority over everything, including a same-cycle write.

## Configuration
- `RECORD_CLEAR_EN` defined:
  - the `clr_req` port and CLEAR state exist;
  - the wipe takes DEPTH cycles;
  - `busy` is driven as above.
- `RECORD_CLEAR_EN` undefined:
  - no `clr_req` port;
  - single-state FSM (SERVE);
  - `busy` is constant 0;
  - `count` can only return to 0 through `rst`.

## Test plan
- DEPTH=4, append records with score 10, 20, 30. Then reader 0 reads IDs 0, 1, 2, 3 → `rd_data.score` = 30, 20, 10 with `rd_hit` = 1; ID 3 returns `rd_hit` = 0 and zero data; `count` = 3.
- DEPTH=4, append scores 1..6 → `count` = 4; IDs 0..3 return scores 6, 5, 4, 3.
- Both readers hold requests for 4 cycles → grants alternate 0, 1, 0, 1, each followed one cycle later by `rd_valid` 01, 10, 01, 10.
- Same cycle: `wr_req` (score 99) and reader 1 with ID 0 → `wr_ack` first; reader 1 granted next cycle and receives score 99.
- With `RECORD_CLEAR_EN`, DEPTH=4, `count` = 3, pulse `clr_req` → `busy` high for 4 cycles; `wr_req` held is not acked until `busy` falls; afterwards a read of ID 0 gives `rd_hit` = 0.
- Assert `rst` during cycle 2 of CLEAR → the next cycle shows SERVE, `busy` 0, `count` 0; a subsequent append followed by a read of ID 0 returns the new record.

Source files
------------

// File: rtl/record_store_arbiter.sv
// Play-record ring buffer shared by one appending writer and two round-robin readers.
// Define RECORD_CLEAR_EN to add the clr_req port and the slot-by-slot CLEAR wipe.
package record_store_pkg;
    typedef struct packed {
        logic [7:0]  player;
        logic [15:0] score;
        logic [7:0]  level;
    } play_record_t;

`ifdef RECORD_CLEAR_EN
    typedef enum logic {SERVE = 1'b0, CLEAR = 1'b1} arb_state_t;
`else
    typedef enum logic {SERVE = 1'b0} arb_state_t;
`endif
endpackage

module record_store_arbiter
    import record_store_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic               prog_clk,
    input  logic               rst,
    input  logic               wr_req,
    input  play_record_t       wr_rec,
    output logic               wr_ack,
    input  logic [1:0]         rd_req,
    input  logic [1:0][7:0]    rd_id,
    output logic [1:0]         rd_gnt,
    output logic [1:0]         rd_valid,
    output logic               rd_hit,
    output play_record_t       rd_data,
    output logic [7:0]         count,
    output logic               busy,
`ifdef RECORD_CLEAR_EN
    input  logic               clr_req,
`endif
    output arb_state_t         state_dbg
);
    // Handshake: wr_ack/rd_gnt are combinational responses to a held request;
    // the access completes at the closing edge of the cycle in which they are high.

    localparam int AW = $clog2(DEPTH);

    arb_state_t   state, state_next;
    logic [AW-1:0] wr_ptr;
    logic          rr;
    play_record_t  mem [DEPTH];

    logic          sel;
    logic [7:0]    sel_id;
    logic [7:0]    slot_full;
    logic [AW-1:0] rd_slot;
    logic          sel_hit;

`ifdef RECORD_CLEAR_EN
    logic [AW-1:0] clr_idx;
`endif

    assign state_dbg = state;

    always_comb begin
        state_next = state;
        wr_ack     = 1'b0;
        rd_gnt     = 2'b00;
        busy       = 1'b0;
        case (state)
            SERVE: begin
`ifdef RECORD_CLEAR_EN
                if (clr_req)
                    state_next = CLEAR;
                else
`endif
                if (wr_req)
                    wr_ack = 1'b1;
                else if (rd_req == 2'b11)
                    rd_gnt = rr ? 2'b10 : 2'b01;
                else
                    rd_gnt = rd_req;
            end
`ifdef RECORD_CLEAR_EN
            CLEAR: begin
                busy = 1'b1;
                if (clr_idx == AW'(DEPTH - 1))
                    state_next = SERVE;
            end
`endif
            default: state_next = SERVE;
        endcase
    end

    // Logical ID 0 is the newest record, just behind the write pointer.
    always_comb begin
        sel       = rd_gnt[1];
        sel_id    = rd_id[sel];
        slot_full = 8'(wr_ptr) - 8'd1 - sel_id;
        rd_slot   = slot_full[AW-1:0];
        sel_hit   = (sel_id < count);
    end

    always_ff @(posedge prog_clk) begin
        if (rst) begin
            state    <= SERVE;
            wr_ptr   <= '0;
            count    <= 8'd0;
            rr       <= 1'b0;
            rd_valid <= 2'b00;
            rd_hit   <= 1'b0;
            rd_data  <= '0;
`ifdef RECORD_CLEAR_EN
            clr_idx  <= '0;
`endif
        end else begin
            state    <= state_next;
            rd_valid <= rd_gnt;
            rd_hit   <= 1'b0;
            if (|rd_gnt) begin
                rr      <= ~sel;
                rd_hit  <= sel_hit;
                rd_data <= sel_hit ? mem[rd_slot] : '0;
            end
            if (wr_ack) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (count != 8'(DEPTH))
                    count <= count + 8'd1;
            end
`ifdef RECORD_CLEAR_EN
            if (state == SERVE && state_next == CLEAR) begin
                count   <= 8'd0;
                wr_ptr  <= '0;
                clr_idx <= '0;
            end else if (state == CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
            end
`endif
        end
    end

    // Storage is not reset; count hides stale slots, and rst blocks any write.
    always_ff @(posedge prog_clk) begin
        if (!rst) begin
            if (wr_ack)
                mem[wr_ptr] <= wr_rec;
`ifdef RECORD_CLEAR_EN
            else if (busy)
                mem[clr_idx] <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_record_store_arbiter.sv
// Directed bench for record_store_arbiter at DEPTH=4: append/read, wrap, round-robin,
// write/read collision, reset priority, and (with RECORD_CLEAR_EN) the wipe.
module tb_record_store_arbiter;
    import record_store_pkg::*;

    localparam int DEPTH = 4;

    logic            prog_clk;
    logic            rst;
    logic            wr_req;
    play_record_t    wr_rec;
    logic            wr_ack;
    logic [1:0]      rd_req;
    logic [1:0][7:0] rd_id;
    logic [1:0]      rd_gnt;
    logic [1:0]      rd_valid;
    logic            rd_hit;
    play_record_t    rd_data;
    logic [7:0]      count;
    logic            busy;
    arb_state_t      state_dbg;
`ifdef RECORD_CLEAR_EN
    logic            clr_req;
`endif

    int checks   = 0;
    int failures = 0;

    record_store_arbiter #(.DEPTH(DEPTH)) dut (
        .prog_clk  (prog_clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_rec    (wr_rec),
        .wr_ack    (wr_ack),
        .rd_req    (rd_req),
        .rd_id     (rd_id),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data),
        .count     (count),
        .busy      (busy),
`ifdef RECORD_CLEAR_EN
        .clr_req   (clr_req),
`endif
        .state_dbg (state_dbg)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    function automatic play_record_t mk_rec(input logic [15:0] s);
        play_record_t r;
        r.player = s[7:0] ^ 8'h5A;
        r.score  = s;
        r.level  = s[7:0] + 8'd1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge prog_clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] s);
        wr_rec = mk_rec(s);
        wr_req = 1'b1;
        #1;
        chk("wr_ack", 64'(wr_ack), 64'd1);
        tick();
        wr_req = 1'b0;
        wr_rec = '0;
    endtask

    task automatic do_read(input int k, input logic [7:0] id, input logic exp_hit,
                           input logic [15:0] s);
        logic [1:0]   exp_onehot;
        play_record_t exp_rec;
        exp_onehot = (k == 1) ? 2'b10 : 2'b01;
        exp_rec    = exp_hit ? mk_rec(s) : '0;
        rd_id[k]   = id;
        rd_req[k]  = 1'b1;
        #1;
        chk("rd_gnt", 64'(rd_gnt), 64'(exp_onehot));
        tick();
        rd_req = 2'b00;
        chk("rd_valid", 64'(rd_valid), 64'(exp_onehot));
        chk("rd_hit", 64'(rd_hit), 64'(exp_hit));
        chk("rd_data", 64'(rd_data), 64'(exp_rec));
    endtask

    initial begin
        rst    = 1'b1;
        wr_req = 1'b0;
        wr_rec = '0;
        rd_req = 2'b00;
        rd_id  = '0;
`ifdef RECORD_CLEAR_EN
        clr_req = 1'b0;
`endif
        do_reset();

        chk("reset_count", 64'(count), 64'd0);
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_rd_hit", 64'(rd_hit), 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_state", 64'(state_dbg), 64'(SERVE));
        chk("idle_wr_ack", 64'(wr_ack), 64'd0);

        // Three appends, newest-first readback, miss beyond count.
        do_write(16'd10);
        do_write(16'd20);
        do_write(16'd30);
        chk("count_3", 64'(count), 64'd3);
        do_read(0, 8'd0, 1'b1, 16'd30);
        do_read(0, 8'd1, 1'b1, 16'd20);
        do_read(0, 8'd2, 1'b1, 16'd10);
        do_read(0, 8'd3, 1'b0, 16'd0);

        // Overfill: count saturates and the oldest records are overwritten.
        do_reset();
        for (int i = 1; i <= 6; i++) do_write(16'(i));
        chk("count_sat", 64'(count), 64'd4);
        do_read(0, 8'd0, 1'b1, 16'd6);
        do_read(0, 8'd1, 1'b1, 16'd5);
        do_read(0, 8'd2, 1'b1, 16'd4);
        do_read(0, 8'd3, 1'b1, 16'd3);
        do_read(1, 8'd200, 1'b0, 16'd0);

        // Both readers held: alternate starting with reader 0.
        do_reset();
        do_write(16'd5);
        rd_id  = '0;
        rd_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_gnt", 64'(rd_gnt), (i % 2 == 0) ? 64'd1 : 64'd2);
            tick();
            chk("rr_valid", 64'(rd_valid), (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        rd_req = 2'b00;

        // Write beats a same-cycle read; the read then sees the new record as ID 0.
        wr_rec   = mk_rec(16'd99);
        wr_req   = 1'b1;
        rd_id[1] = 8'd0;
        rd_req   = 2'b10;
        #1;
        chk("coll_wr_ack", 64'(wr_ack), 64'd1);
        chk("coll_rd_gnt", 64'(rd_gnt), 64'd0);
        tick();
        wr_req = 1'b0;
        #1;
        chk("coll_rd_gnt_next", 64'(rd_gnt), 64'd2);
        tick();
        rd_req = 2'b00;
        chk("coll_rd_valid", 64'(rd_valid), 64'd2);
        chk("coll_rd_hit", 64'(rd_hit), 64'd1);
        chk("coll_rd_data", 64'(rd_data), 64'(mk_rec(16'd99)));

        // Reset wins over a same-cycle write.
        rst    = 1'b1;
        wr_rec = mk_rec(16'd44);
        wr_req = 1'b1;
        tick();
        rst    = 1'b0;
        wr_req = 1'b0;
        chk("rst_wr_count", 64'(count), 64'd0);
        do_read(0, 8'd0, 1'b0, 16'd0);

`ifdef RECORD_CLEAR_EN
        // Wipe lasts DEPTH cycles and blocks a held write until it finishes.
        do_reset();
        do_write(16'd10);
        do_write(16'd20);
        do_write(16'd30);
        clr_req = 1'b1;
        #1;
        chk("clr_entry_busy", 64'(busy), 64'd0);
        tick();
        clr_req = 1'b0;
        wr_rec  = mk_rec(16'd77);
        wr_req  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("clr_busy", 64'(busy), 64'd1);
            chk("clr_wr_ack", 64'(wr_ack), 64'd0);
            chk("clr_count", 64'(count), 64'd0);
            tick();
        end
        #1;
        chk("clr_done_busy", 64'(busy), 64'd0);
        chk("clr_done_wr_ack", 64'(wr_ack), 64'd1);
        tick();
        wr_req = 1'b0;
        chk("clr_after_count", 64'(count), 64'd1);
        do_read(0, 8'd0, 1'b1, 16'd77);
        do_read(0, 8'd1, 1'b0, 16'd0);

        // Reset in the second wipe cycle aborts the wipe.
        do_reset();
        do_write(16'd10);
        do_write(16'd20);
        do_write(16'd30);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        chk("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_state", 64'(state_dbg), 64'(SERVE));
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_count", 64'(count), 64'd0);
        do_write(16'd55);
        do_read(0, 8'd0, 1'b1, 16'd55);
        do_read(1, 8'd1, 1'b0, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
